traffic_phase_ctrl: RTL

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/phase_timer.sv | 30 +++
 rtl/traffic_phase_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-signal types: controller state encoding, lamp drive levels, timer sizing helpers.
// Latency: n/a (types and constants only); backpressure: n/a.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

    function automatic int max_dur(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one controller phase; zero flags the last cycle of the phase.
// Latency: load takes effect on the next edge; backpressure: none, counter parks at zero until reloaded.
module phase_timer #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign value = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin intersection controller with pedestrian walk requests and flashing-yellow maintenance mode.
// Latency: lamps are registered and change on the same edge as the state; backpressure: none, requests are held sticky.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_HALF = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flash_req,
    input  logic [NUM_DIR-1:0]         ped_req,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         ped_walk,
    output logic [$clog2(NUM_DIR)-1:0] active_dir
);

    localparam int DW   = $clog2(NUM_DIR);
    localparam int MAXD = max_dur(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, FLASH_HALF);
    localparam int TW   = cnt_width(MAXD);

    localparam logic [TW-1:0] LD_GREEN  = TW'(GREEN_CYC - 1);
    localparam logic [TW-1:0] LD_YELLOW = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] LD_ALLRED = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] LD_FLASH  = TW'(FLASH_HALF - 1);
    localparam logic [TW-1:0] LD_MAX    = TW'(MAXD - 1);
    localparam logic [DW-1:0] DIR_LAST  = DW'(NUM_DIR - 1);

    state_t             state, state_nxt;
    logic [DW-1:0]      dir, dir_nxt;
    logic               flash_on, flash_nxt;
    logic [NUM_DIR-1:0] pending, pend_nxt, pend_now;
    logic [NUM_DIR-1:0] red_nxt, yellow_nxt, green_nxt, walk_nxt, dmask;

    logic               tm_load, tm_zero;
    logic [TW-1:0]      tm_ld_val, tm_val;

    phase_timer #(
        .W       (TW),
        .RST_VAL (LD_ALLRED)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tm_load),
        .load_val (tm_ld_val),
        .value    (tm_val),
        .zero     (tm_zero)
    );

    // State and all lamp registers share one reset so reset blanks the lamps without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ALLRED;
            dir      <= DIR_LAST;
            flash_on <= LAMP_OFF;
            pending  <= '0;
            red      <= {NUM_DIR{LAMP_ON}};
            yellow   <= {NUM_DIR{LAMP_OFF}};
            green    <= {NUM_DIR{LAMP_OFF}};
            ped_walk <= {NUM_DIR{LAMP_OFF}};
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            flash_on <= flash_nxt;
            pending  <= pend_nxt;
            red      <= red_nxt;
            yellow   <= yellow_nxt;
            green    <= green_nxt;
            ped_walk <= walk_nxt;
        end
    end

    // Every phase ends on the timer's zero cycle; the timer is reloaded on that same edge.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        flash_nxt = flash_on;
        tm_load   = 1'b0;
        tm_ld_val = LD_ALLRED;
        if (tm_zero) begin
            tm_load = 1'b1;
            unique case (state)
                ST_ALLRED: begin
                    if (flash_req) begin
                        state_nxt = ST_FLASH;
                        tm_ld_val = LD_FLASH;
                        flash_nxt = LAMP_ON;
                    end else begin
                        state_nxt = ST_GREEN;
                        tm_ld_val = LD_GREEN;
                        dir_nxt   = (dir == DIR_LAST) ? '0 : dir + 1'b1;
                    end
                end
                ST_GREEN: begin
                    state_nxt = ST_YELLOW;
                    tm_ld_val = LD_YELLOW;
                end
                ST_YELLOW: begin
                    if (flash_req) begin
                        state_nxt = ST_FLASH;
                        tm_ld_val = LD_FLASH;
                        flash_nxt = LAMP_ON;
                    end else begin
                        state_nxt = ST_ALLRED;
                        tm_ld_val = LD_ALLRED;
                    end
                end
                ST_FLASH: begin
                    if (!flash_req) begin
                        // Leaving maintenance restarts the rotation from approach 0.
                        state_nxt = ST_ALLRED;
                        tm_ld_val = LD_ALLRED;
                        dir_nxt   = DIR_LAST;
                        flash_nxt = LAMP_OFF;
                    end else begin
                        tm_ld_val = LD_FLASH;
                        flash_nxt = ~flash_on;
                    end
                end
                default: begin
                    state_nxt = ST_ALLRED;
                    tm_ld_val = LD_ALLRED;
                end
            endcase
        end
    end

    // Lamp values are decoded from the next state so the registered lamps track the state register.
    always_comb begin
        pend_now   = pending | ped_req;
        pend_nxt   = pend_now;
        dmask      = NUM_DIR'(1) << dir_nxt;
        red_nxt    = {NUM_DIR{LAMP_ON}};
        yellow_nxt = {NUM_DIR{LAMP_OFF}};
        green_nxt  = {NUM_DIR{LAMP_OFF}};
        walk_nxt   = {NUM_DIR{LAMP_OFF}};
        unique case (state_nxt)
            ST_GREEN: begin
                red_nxt   = ~dmask;
                green_nxt = dmask;
                if (state != ST_GREEN) begin
                    walk_nxt = pend_now & dmask;
                    pend_nxt = pend_now & ~dmask;
                end else begin
                    walk_nxt = ped_walk;
                end
            end
            ST_YELLOW: begin
                red_nxt    = ~dmask;
                yellow_nxt = dmask;
            end
            ST_FLASH: begin
                red_nxt    = {NUM_DIR{LAMP_OFF}};
                yellow_nxt = {NUM_DIR{flash_nxt}};
            end
            default: begin
                red_nxt = {NUM_DIR{LAMP_ON}};
            end
        endcase
    end

    assign active_dir = dir;

    a_timer_range: assert property (@(posedge clk) disable iff (!rst_n) tm_val <= LD_MAX);
    a_lamp_excl:   assert property (@(posedge clk) disable iff (!rst_n) (green & yellow) == '0);

endmodule
